// File: rtl/booth_mult_pkg.sv
// booth_mult_pkg: shared FSM states, Booth digit encoding and digit-count helper.
package booth_mult_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  typedef enum logic [2:0] {ZERO, POS1, POS2, NEG1, NEG2} digit_t;
  function automatic int calc_iter(input int width);
    return (width + 2) / 2;
  endfunction
endpackage

// File: rtl/booth_r4_encoder.sv
// booth_r4_encoder: recodes a 3-bit Booth window into magnitude selects and a negate flag.
module booth_r4_encoder
  import booth_mult_pkg::*;
(
  input  logic [2:0] i_win,
  output logic       o_sel1x,
  output logic       o_sel2x,
  output logic       o_neg
);
  digit_t w_digit;
  assign w_digit = (i_win == 3'b001 || i_win == 3'b010) ? POS1 :
                   (i_win == 3'b011)                    ? POS2 :
                   (i_win == 3'b100)                    ? NEG2 :
                   (i_win == 3'b101 || i_win == 3'b110) ? NEG1 : ZERO;
  assign o_sel1x = (w_digit == POS1) || (w_digit == NEG1);
  assign o_sel2x = (w_digit == POS2) || (w_digit == NEG2);
  assign o_neg   = (w_digit == NEG1) || (w_digit == NEG2);
endmodule

// File: rtl/booth_radix4_seq_mult.sv
// booth_radix4_seq_mult: iterative radix-4 Booth multiplier, one partial product per clock,
// with valid/ready operand and result handshakes and per-operation signed/unsigned mode.
module booth_radix4_seq_mult
  import booth_mult_pkg::*;
#(
  parameter int WIDTH = 12
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  input  logic               signed_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] prod,
  output logic               busy
);
  localparam int ITER = calc_iter(WIDTH);
  localparam int AW   = 2*WIDTH + 4;
  localparam int CW   = $clog2(ITER + 1);
  state_t             r_state, w_next;
  logic [AW-1:0]      r_acc, r_a, w_mag, w_pp, w_sum;
  logic [WIDTH+2:0]   r_b;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_prod;
  logic [WIDTH+1:0]   w_exta, w_extb;
  logic               w_sel1x, w_sel2x, w_neg, w_accept, w_last;
  assign w_exta    = {{2{signed_mode & multiplicand[WIDTH-1]}}, multiplicand};
  assign w_extb    = {{2{signed_mode & multiplier[WIDTH-1]}}, multiplier};
  assign in_ready  = (r_state == IDLE);
  assign busy      = (r_state == BUSY);
  assign out_valid = (r_state == DONE);
  assign prod      = r_prod;
  assign w_accept  = in_valid && in_ready;
  assign w_last    = (r_cnt == CW'(ITER - 1));
  booth_r4_encoder u_enc (
    .i_win   (r_b[2:0]),
    .o_sel1x (w_sel1x),
    .o_sel2x (w_sel2x),
    .o_neg   (w_neg)
  );
  // r_a advances by two bit positions per digit, so it always holds A << 2i
  assign w_mag = w_sel2x ? {r_a[AW-2:0], 1'b0} : w_sel1x ? r_a : '0;
  assign w_pp  = w_neg ? ~w_mag + AW'(1) : w_mag;
  assign w_sum = r_acc + w_pp;
  always_comb begin
    w_next = (r_state == IDLE && w_accept)  ? BUSY :
             (r_state == BUSY && w_last)    ? DONE :
             (r_state == DONE && out_ready) ? IDLE : r_state;
  end
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc  <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_cnt  <= '0;
      r_prod <= '0;
    end else if (w_accept) begin
      r_acc <= '0;
      r_a   <= {{(AW-WIDTH-2){w_exta[WIDTH+1]}}, w_exta};
      r_b   <= {w_extb, 1'b0};
      r_cnt <= '0;
    end else if (busy) begin
      r_acc <= w_sum;
      r_a   <= {r_a[AW-3:0], 2'b00};
      r_b   <= {2'b00, r_b[WIDTH+2:2]};
      r_cnt <= r_cnt + CW'(1);
      if (w_last) r_prod <= w_sum[2*WIDTH-1:0];
    end
  end
endmodule

// File: tb/tb_booth_radix4_seq_mult.sv
// tb_booth_radix4_seq_mult: scoreboard bench for WIDTH=12 directed cases and
// WIDTH=4/16 randomised back-to-back traffic with random backpressure.
module tb_booth_radix4_seq_mult;
  logic clk, reset;
  logic iv12, ir12, sm12, ov12, or12, bz12;
  logic [11:0] a12, b12;
  logic [23:0] p12;
  logic iv4, ir4, sm4, ov4, or4, bz4;
  logic [3:0] a4, b4;
  logic [7:0] p4;
  logic iv16, ir16, sm16, ov16, or16, bz16;
  logic [15:0] a16, b16;
  logic [31:0] p16;
  logic [23:0] q12[$];
  logic [7:0]  q4[$];
  logic [31:0] q16[$];
  int checks = 0;
  int errors = 0;

  booth_radix4_seq_mult #(.WIDTH(12)) u12 (
    .clk(clk), .reset(reset), .in_valid(iv12), .in_ready(ir12), .multiplicand(a12),
    .multiplier(b12), .signed_mode(sm12), .out_valid(ov12), .out_ready(or12),
    .prod(p12), .busy(bz12));
  booth_radix4_seq_mult #(.WIDTH(4)) u4 (
    .clk(clk), .reset(reset), .in_valid(iv4), .in_ready(ir4), .multiplicand(a4),
    .multiplier(b4), .signed_mode(sm4), .out_valid(ov4), .out_ready(or4),
    .prod(p4), .busy(bz4));
  booth_radix4_seq_mult #(.WIDTH(16)) u16 (
    .clk(clk), .reset(reset), .in_valid(iv16), .in_ready(ir16), .multiplicand(a16),
    .multiplier(b16), .signed_mode(sm16), .out_valid(ov16), .out_ready(or16),
    .prod(p16), .busy(bz16));

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_mul(input int w, input logic [15:0] a, input logic [15:0] b,
                                          input logic sm);
    longint m = (longint'(1) << w) - 1;
    longint x = longint'(a) & m;
    longint y = longint'(b) & m;
    if (sm && x[w-1]) x = x - (longint'(1) << w);
    if (sm && y[w-1]) y = y - (longint'(1) << w);
    return 32'((x * y) & ((longint'(1) << (2*w)) - 1));
  endfunction

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (ir12 !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", ir12); end
    checks++; if (ov12 !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", ov12); end
    checks++; if (bz12 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bz12); end
    checks++; if (p12 !== 24'h0) begin errors++; $display("FAIL reset_prod: got %h want 0", p12); end
    checks++; if ({ir4, ov4, bz4, ir16, ov16, bz16} !== 6'b100100)
      begin errors++; $display("FAIL reset_w4_w16: got %b want 100100", {ir4, ov4, bz4, ir16, ov16, bz16}); end
    reset = 0;
  endtask

  task automatic run12(input int a, input int b, input logic sm, input logic [23:0] exp, input string nm);
    int n = 0;
    logic [23:0] e;
    q12.push_back(exp);
    @(negedge clk);
    iv12 = 1; a12 = 12'(a); b12 = 12'(b); sm12 = sm;
    @(negedge clk);
    iv12 = 0; a12 = 12'd99; b12 = 12'd99; sm12 = ~sm;
    while (!ov12 && n < 20) begin @(negedge clk); n++; end
    checks++; if (n != 7) begin errors++; $display("FAIL %s_latency: got %0d edges want 7", nm, n); end
    if (ov12) begin
      e = q12.pop_front();
      checks++; if (p12 !== e) begin errors++; $display("FAIL %s: prod %h want %h", nm, p12, e); end
    end
    @(negedge clk);
    checks++; if (ir12 !== 1'b1 || ov12 !== 1'b0)
      begin errors++; $display("FAIL %s_pop: in_ready=%b out_valid=%b want 1 0", nm, ir12, ov12); end
  endtask

  task automatic test_signed();
    run12(25, 15, 1, 24'h000177, "s_25x15");
    run12(-30, -40, 1, 24'd1200, "s_m30xm40");
    run12(-25, 30, 1, 24'hFFFD12, "s_m25x30");
    run12(30, -15, 1, 24'(-450), "s_30xm15");
    run12(100, 3, 1, 24'd300, "s_100x3");
    run12(80, -56, 1, 24'hFFEE80, "s_80xm56");
  endtask

  task automatic test_extremes();
    run12(-2048, -2048, 1, 24'h400000, "s_min_min");
    run12(2047, -2048, 1, 24'hC00800, "s_max_min");
    run12(4095, 4095, 0, 24'hFFE001, "u_max_max");
    run12(4095, 1, 0, 24'h000FFF, "u_max_one");
  endtask

  task automatic test_operand_change();
    run12(25, 15, 1, 24'h000177, "hold_operands");
  endtask

  task automatic test_backpressure();
    int n = 0;
    logic [23:0] e;
    or12 = 0;
    q12.push_back(24'hFFFCA3);
    @(negedge clk);
    iv12 = 1; a12 = 12'd123; b12 = 12'(-7); sm12 = 1;
    @(negedge clk);
    iv12 = 0;
    while (!ov12 && n < 20) begin @(negedge clk); n++; end
    for (int k = 0; k < 5; k++) begin
      iv12 = (k == 2); a12 = 12'd5; b12 = 12'd5;
      checks++; if (ov12 !== 1'b1 || ir12 !== 1'b0 || p12 !== 24'hFFFCA3)
        begin errors++; $display("FAIL bp_hold_%0d: ov=%b ir=%b prod=%h want 1 0 fffca3", k, ov12, ir12, p12); end
      @(negedge clk);
    end
    iv12 = 0; or12 = 1;
    e = q12.pop_front();
    checks++; if (p12 !== e) begin errors++; $display("FAIL bp_prod: prod %h want %h", p12, e); end
    @(negedge clk);
    checks++; if (ov12 !== 1'b0 || ir12 !== 1'b1 || bz12 !== 1'b0)
      begin errors++; $display("FAIL bp_release: ov=%b ir=%b busy=%b want 0 1 0", ov12, ir12, bz12); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    iv12 = 1; a12 = 12'd100; b12 = 12'd3; sm12 = 1;
    @(negedge clk);
    iv12 = 0;
    repeat (2) @(negedge clk);
    reset = 1;
    @(negedge clk);
    checks++; if (ov12 !== 1'b0 || bz12 !== 1'b0 || ir12 !== 1'b1 || p12 !== 24'h0)
      begin errors++; $display("FAIL mid_reset: ov=%b busy=%b ir=%b prod=%h want 0 0 1 0", ov12, bz12, ir12, p12); end
    reset = 0;
    run12(7, -3, 1, 24'(-21), "after_reset");
  endtask

  task automatic drive4(input int n);
    int g;
    logic [31:0] r;
    for (int i = 0; i < n; i++) begin
      a4 = 4'($urandom); b4 = 4'($urandom); sm4 = 1'($urandom); iv4 = 1;
      g = 0;
      while (!ir4 && g < 200) begin @(negedge clk); g++; end
      if (g == 200) begin checks++; errors++; $display("FAIL w4_accept_timeout: op %0d", i); end
      r = ref_mul(4, 16'(a4), 16'(b4), sm4);
      q4.push_back(r[7:0]);
      @(negedge clk);
    end
    iv4 = 0;
  endtask

  task automatic mon4(input int n);
    int got = 0, cyc = 0;
    logic [7:0] e;
    while (got < n && cyc < n * 40) begin
      @(negedge clk); cyc++;
      or4 = 1'($urandom);
      if (ov4 && or4) begin
        checks++;
        if (q4.size() == 0) begin errors++; $display("FAIL w4_extra: prod %h with empty queue", p4); end
        else begin
          e = q4.pop_front();
          if (p4 !== e) begin errors++; $display("FAIL w4_prod: prod %h want %h", p4, e); end
        end
        got++;
      end
    end
    checks++; if (got != n || q4.size() != 0)
      begin errors++; $display("FAIL w4_count: got %0d want %0d, %0d left", got, n, q4.size()); end
    or4 = 0;
  endtask

  task automatic drive16(input int n);
    int g;
    for (int i = 0; i < n; i++) begin
      a16 = 16'($urandom); b16 = 16'($urandom); sm16 = 1'($urandom); iv16 = 1;
      g = 0;
      while (!ir16 && g < 200) begin @(negedge clk); g++; end
      if (g == 200) begin checks++; errors++; $display("FAIL w16_accept_timeout: op %0d", i); end
      q16.push_back(ref_mul(16, a16, b16, sm16));
      @(negedge clk);
    end
    iv16 = 0;
  endtask

  task automatic mon16(input int n);
    int got = 0, cyc = 0;
    logic [31:0] e;
    while (got < n && cyc < n * 40) begin
      @(negedge clk); cyc++;
      or16 = 1'($urandom);
      if (ov16 && or16) begin
        checks++;
        if (q16.size() == 0) begin errors++; $display("FAIL w16_extra: prod %h with empty queue", p16); end
        else begin
          e = q16.pop_front();
          if (p16 !== e) begin errors++; $display("FAIL w16_prod: prod %h want %h", p16, e); end
        end
        got++;
      end
    end
    checks++; if (got != n || q16.size() != 0)
      begin errors++; $display("FAIL w16_count: got %0d want %0d, %0d left", got, n, q16.size()); end
    or16 = 0;
  endtask

  task automatic test_back_to_back();
    fork
      drive4(1000);
      mon4(1000);
      drive16(1000);
      mon16(1000);
    join
  endtask

  initial begin
    clk = 0; reset = 1;
    iv12 = 0; a12 = '0; b12 = '0; sm12 = 0; or12 = 1;
    iv4 = 0; a4 = '0; b4 = '0; sm4 = 0; or4 = 0;
    iv16 = 0; a16 = '0; b16 = '0; sm16 = 0; or16 = 0;
    test_reset();
    test_signed();
    test_extremes();
    test_operand_change();
    test_backpressure();
    test_reset_mid();
    @(negedge clk);
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
